mem_data_lsu: RTL and testbench

//  Load/store sequencer between the core's memory stage and the 32b word-only

---
 rtl/mem_data_lsu.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_data_lsu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_lsu.sv
// mem_data_lsu: load/store sequencer between the memory stage and a 32-bit
// word-only data RAM with a 1-cycle registered read.
// Sub-word stores are done as read-modify-write. Sub-word loads are sign- or
// zero-extended. Misaligned or illegal requests complete with an error and
// never touch the RAM.
// Optional feature: define MEM_DATA_LSU_BOUNDS_EN to reject aligned requests
// whose address lies at or beyond ROWS*4 bytes.
module mem_data_lsu #(
    parameter int ROWS = 512
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic [31:0] resp_rdata_o,
    output logic        mem_r_en_o,
    output logic [31:0] mem_addr_r_o,
    input  logic [31:0] mem_data_r_i,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_w_o,
    output logic [31:0] mem_data_w_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LDATA = 3'd2,
        S_MERGE = 3'd3,
        S_WR    = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        we_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        accept_s;
    logic        misaligned_s;
    logic        out_of_range_s;
    logic [31:0] word_addr_s;

    // A RAM with no rows is a configuration mistake; stop at elaboration.
    if (ROWS < 1) begin : g_rows_check
        $error("mem_data_lsu: ROWS must be at least 1");
    end

    // Pick the addressed byte/half out of a RAM word and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane(s) of an old RAM word with right-aligned store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00:   res[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01:   res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

`ifdef MEM_DATA_LSU_BOUNDS_EN
    localparam logic [31:0] ROW_BYTES = 32'(ROWS) << 2;
    assign out_of_range_s = (req_addr_i >= ROW_BYTES);
`else
    // Out-of-range addresses pass through; the RAM aliases them by truncation.
    assign out_of_range_s = 1'b0;
`endif

    assign accept_s    = req_valid_i && req_ready_o;
    assign word_addr_s = {addr_r[31:2], 2'b00};

    // Alignment check on the incoming request; size 11 is always illegal.
    always_comb begin
        misaligned_s = 1'b0;
        case (req_size_i)
            2'b00:   misaligned_s = 1'b0;
            2'b01:   misaligned_s = req_addr_i[0];
            2'b10:   misaligned_s = (req_addr_i[1:0] != 2'b00);
            default: misaligned_s = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request field capture on accept; fields are held until the next accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_r       <= 1'b0;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r       <= req_we_i;
            size_r     <= req_size_i;
            unsigned_r <= req_unsigned_i;
            addr_r     <= req_addr_i;
            wdata_r    <= req_wdata_i;
        end else begin
            we_r       <= we_r;
            size_r     <= size_r;
            unsigned_r <= unsigned_r;
            addr_r     <= addr_r;
            wdata_r    <= wdata_r;
        end
    end

    // Next-state logic: word stores skip the read; everything else not in error reads first.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (misaligned_s || out_of_range_s) begin
                        state_next_s = S_ERR;
                    end else if (req_we_i && (req_size_i == 2'b10)) begin
                        state_next_s = S_WR;
                    end else begin
                        state_next_s = S_RD;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RD: begin
                if (we_r) begin
                    state_next_s = S_MERGE;
                end else begin
                    state_next_s = S_LDATA;
                end
            end
            S_LDATA: state_next_s = S_IDLE;
            S_MERGE: state_next_s = S_IDLE;
            S_WR:    state_next_s = S_IDLE;
            S_ERR:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output decode from state; everything is forced quiet while reset is high.
    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        resp_rdata_o = 32'h0000_0000;
        mem_r_en_o   = 1'b0;
        mem_addr_r_o = 32'h0000_0000;
        mem_wr_en_o  = 1'b0;
        mem_addr_w_o = 32'h0000_0000;
        mem_data_w_o = 32'h0000_0000;
        if (rst_i) begin
            req_ready_o = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: req_ready_o = 1'b1;
                S_RD: begin
                    mem_r_en_o   = 1'b1;
                    mem_addr_r_o = word_addr_s;
                end
                S_LDATA: begin
                    resp_valid_o = 1'b1;
                    resp_rdata_o = extract_load(mem_data_r_i, addr_r[1:0], size_r, unsigned_r);
                end
                S_MERGE: begin
                    mem_wr_en_o  = 1'b1;
                    mem_addr_w_o = word_addr_s;
                    mem_data_w_o = merge_store(mem_data_r_i, wdata_r, addr_r[1:0], size_r);
                    resp_valid_o = 1'b1;
                end
                S_WR: begin
                    mem_wr_en_o  = 1'b1;
                    mem_addr_w_o = word_addr_s;
                    mem_data_w_o = wdata_r;
                    resp_valid_o = 1'b1;
                end
                S_ERR: begin
                    resp_valid_o = 1'b1;
                    resp_err_o   = 1'b1;
                end
                default: req_ready_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_data_lsu.sv
// tb_mem_data_lsu: directed plus randomized checks of mem_data_lsu against a
// golden word array updated with plain mask/shift arithmetic. A simple
// registered-read RAM is attached to the DUT memory ports.
module tb_mem_data_lsu;

    localparam int ROWS = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_r_en;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_data_r;
    logic        mem_wr_en;
    logic [31:0] mem_addr_w;
    logic [31:0] mem_data_w;

    logic [31:0] ram  [0:ROWS-1] = '{default: 32'h0};
    logic [31:0] gold [0:ROWS-1] = '{default: 32'h0};
    logic [31:0] ram_q = 32'h0;

    int errors = 0;
    int checks = 0;

    mem_data_lsu #(.ROWS(ROWS)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_err_o(resp_err), .resp_rdata_o(resp_rdata),
        .mem_r_en_o(mem_r_en), .mem_addr_r_o(mem_addr_r), .mem_data_r_i(mem_data_r),
        .mem_wr_en_o(mem_wr_en), .mem_addr_w_o(mem_addr_w), .mem_data_w_o(mem_data_w)
    );

    always #5 clk = ~clk;

    // Attached RAM: registered read, word write, index truncated to ROWS.
    always @(posedge clk) begin
        if (mem_wr_en) ram[(mem_addr_w >> 2) % ROWS] <= mem_data_w;
        if (mem_r_en) ram_q <= ram[(mem_addr_r >> 2) % ROWS];
    end
    assign mem_data_r = ram_q;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] v;
        int sh;
        if (size == 2'b00) begin
            sh = 8 * int'(addr[1:0]);
            v = (word >> sh) & 32'h0000_00FF;
            if (!uns && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            sh = 16 * int'(addr[1]);
            v = (word >> sh) & 32'h0000_FFFF;
            if (!uns && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] mask;
        int sh;
        if (size == 2'b00) begin
            sh = 8 * int'(addr[1:0]);
            mask = 32'h0000_00FF << sh;
            return (old & ~mask) | ((wdata & 32'h0000_00FF) << sh);
        end else if (size == 2'b01) begin
            sh = 16 * int'(addr[1]);
            mask = 32'h0000_FFFF << sh;
            return (old & ~mask) | ((wdata & 32'h0000_FFFF) << sh);
        end
        return wdata;
    endfunction

    // One request, watched for four cycles after acceptance.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        logic misal, oor, err;
        int idx, exp_lat, exp_reads, exp_writes;
        int got_lat, resp_cnt, reads, writes;
        logic [31:0] exp_rdata, got_rdata, got_err, got_waddr;
        misal = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
`ifdef MEM_DATA_LSU_BOUNDS_EN
        oor = (addr >= 32'(ROWS * 4));
`else
        oor = 1'b0;
`endif
        err = misal || oor;
        idx = int'((addr >> 2) % ROWS);
        exp_lat    = (err || (we && size == 2'b10)) ? 1 : 2;
        exp_rdata  = (err || we) ? 32'h0 : ref_load(gold[idx], addr, size, uns);
        exp_reads  = (!err && (!we || size != 2'b10)) ? 1 : 0;
        exp_writes = (!err && we) ? 1 : 0;
        got_lat = 0; resp_cnt = 0; reads = 0; writes = 0;
        got_rdata = 32'h0; got_err = 32'h0; got_waddr = 32'h0;

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        check_eq({tag, ":ready_idle"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check_eq({tag, ":ready_busy"}, {31'h0, req_ready}, 32'h0);
            check_eq({tag, ":en_excl"}, {31'h0, mem_r_en & mem_wr_en}, 32'h0);
            if (mem_r_en) begin
                reads++;
                check_eq({tag, ":raddr"}, mem_addr_r, {addr[31:2], 2'b00});
            end
            if (mem_wr_en) begin
                writes++;
                got_waddr = mem_addr_w;
            end
            if (resp_valid) begin
                resp_cnt++;
                if (got_lat == 0) begin
                    got_lat = cyc;
                    got_err = {31'h0, resp_err};
                    got_rdata = resp_rdata;
                end
            end
        end
        check_eq({tag, ":latency"}, 32'(got_lat), 32'(exp_lat));
        check_eq({tag, ":resp_cnt"}, 32'(resp_cnt), 32'h1);
        check_eq({tag, ":err"}, got_err, {31'h0, err});
        check_eq({tag, ":rdata"}, got_rdata, exp_rdata);
        check_eq({tag, ":reads"}, 32'(reads), 32'(exp_reads));
        check_eq({tag, ":writes"}, 32'(writes), 32'(exp_writes));
        if (exp_writes == 1) begin
            check_eq({tag, ":waddr"}, got_waddr, {addr[31:2], 2'b00});
            gold[idx] = ref_store(gold[idx], wdata, addr, size);
            check_eq({tag, ":ram_word"}, ram[idx], gold[idx]);
        end
    endtask

    initial begin
        logic        r_we, r_uns;
        logic [1:0]  r_size;
        logic [31:0] r_addr;

        // Reset: outputs quiet, a pending valid is not accepted.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40;
        req_wdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check_eq("rst:ready", {31'h0, req_ready}, 32'h0);
        check_eq("rst:resp", {30'h0, resp_valid, resp_err}, 32'h0);
        check_eq("rst:en", {30'h0, mem_r_en, mem_wr_en}, 32'h0);
        check_eq("rst:rdata", resp_rdata, 32'h0);
        check_eq("rst:wdata", mem_data_w, 32'h0);
        check_eq("rst:addr", mem_addr_r | mem_addr_w, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;

        // Directed scenarios.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, "t1_sw");
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "t1_lw");
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_005A, "t2_sb");
        check_eq("t2_word", ram[4], 32'hDEAD_5AEF);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, "t2_lb11");
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "t2_lb13s");
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "t2_lb13u");
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, "t3_sh");
        check_eq("t3_word", ram[4], 32'h8001_5AEF);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "t3_lh");
        do_req(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, "t4_lh_mis");
        do_req(1'b1, 2'b10, 1'b0, 32'h02, 32'hFFFF_FFFF, "t4_sw_mis");
        do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, "t4_ill");
        do_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, "t6_lw800");

        // Reset while a byte store sits in its read phase.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h0000_00A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0; rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("t5:ready_rst", {31'h0, req_ready}, 32'h0);
            check_eq("t5:resp_rst", {31'h0, resp_valid}, 32'h0);
            check_eq("t5:wr_rst", {31'h0, mem_wr_en}, 32'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5:ready_after", {31'h0, req_ready}, 32'h1);
        check_eq("t5:resp_after", {31'h0, resp_valid}, 32'h0);
        check_eq("t5:wr_after", {31'h0, mem_wr_en}, 32'h0);
        check_eq("t5:word", ram[8], gold[8]);
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, "t5_lb");

        // Randomized traffic, mostly aligned, mostly in a small window.
        for (int n = 0; n < 300; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_uns  = 1'($urandom_range(0, 1));
            r_size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r_addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (r_size == 2'b01) r_addr[0] = 1'b0;
                if (r_size == 2'b10) r_addr[1:0] = 2'b00;
            end
            do_req(r_we, r_size, r_uns, r_addr, $urandom, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
